// File: rtl/operand_entry.sv
// Keypad operand entry: builds a signed decimal operand from key events and
// commits it to op1_o on ENTER with a one-cycle enter_o pulse.
// Optional backspace support is enabled with `define OPERAND_ENTRY_BKSP_EN.
module operand_entry #(
  parameter int unsigned Width     = 9,
  parameter int unsigned MaxDigits = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             key_valid_i,
  input  logic [3:0]       key_code_i,
  output logic [Width-1:0] op1_o,
  output logic             enter_o,
  output logic [Width-1:0] entry_val_o,
  output logic [1:0]       digit_count_o,
  output logic             neg_o,
  output logic             err_o
);

  localparam int unsigned MagW  = Width + 1;
  localparam int unsigned CandW = MagW + 4;

  localparam logic [CandW-1:0] PosMax = CandW'((1 << (Width - 1)) - 1);
  localparam logic [CandW-1:0] NegMax = CandW'(1 << (Width - 1));
  localparam logic [1:0]       MaxCnt = 2'(MaxDigits);

  localparam logic [3:0] KeyNeg   = 4'd10;
  localparam logic [3:0] KeyClr   = 4'd11;
  localparam logic [3:0] KeyBksp  = 4'd12;
  localparam logic [3:0] KeyEnter = 4'd13;

  typedef enum logic [1:0] {StEmpty, StEntry, StError} state_e;

  state_e           state_q, state_d;
  logic [MagW-1:0]  mag_q, mag_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [Width-1:0] op1_q, op1_d;
  logic [Width-1:0] entry_val_q, entry_val_d;
  logic             enter_q, enter_d;
  logic             err_q, err_d;

  logic [CandW-1:0] cand;
  logic [CandW-1:0] limit;

`ifdef OPERAND_ENTRY_BKSP_EN
  logic [MagW-1:0] stack_q [MaxDigits];
  logic            push_en;
`endif

  // Key decode, range checking and FSM next-state.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    op1_d   = op1_q;
    enter_d = 1'b0;
    err_d   = 1'b0;
`ifdef OPERAND_ENTRY_BKSP_EN
    push_en = 1'b0;
`endif
    cand  = CandW'(mag_q) * CandW'(10) + CandW'(key_code_i);
    limit = neg_q ? NegMax : PosMax;

    if (key_valid_i) begin
      if (key_code_i <= 4'd9) begin
        if (state_q == StError) begin
          err_d = 1'b1;
        end else if (cnt_q == MaxCnt) begin
          // Typing past the digit limit locks the entry until CLR/ENTER/BKSP.
          err_d   = 1'b1;
          state_d = StError;
        end else if (cand > limit) begin
          err_d = 1'b1;
        end else begin
          mag_d   = cand[MagW-1:0];
          cnt_d   = cnt_q + 2'd1;
          state_d = StEntry;
`ifdef OPERAND_ENTRY_BKSP_EN
          push_en = 1'b1;
`endif
        end
      end else begin
        case (key_code_i)
          KeyNeg: begin
            // Dropping the sign of -256 would leave an unrepresentable +256.
            if (state_q == StError || (neg_q && CandW'(mag_q) > PosMax)) begin
              err_d = 1'b1;
            end else begin
              neg_d = ~neg_q;
            end
          end
          KeyClr: begin
            mag_d   = '0;
            cnt_d   = '0;
            neg_d   = 1'b0;
            state_d = StEmpty;
          end
          KeyEnter: begin
            if (state_q == StEmpty) begin
              err_d = 1'b1;
            end else begin
              op1_d   = entry_val_q;
              enter_d = 1'b1;
              mag_d   = '0;
              cnt_d   = '0;
              neg_d   = 1'b0;
              state_d = StEmpty;
            end
          end
`ifdef OPERAND_ENTRY_BKSP_EN
          KeyBksp: begin
            if (cnt_q == 2'd0) begin
              err_d = 1'b1;
            end else begin
              mag_d   = stack_q[cnt_q - 2'd1];
              cnt_d   = cnt_q - 2'd1;
              state_d = (cnt_q == 2'd1) ? StEmpty : StEntry;
            end
          end
`endif
          default: ;
        endcase
      end
    end

    entry_val_d = Width'(neg_d ? (MagW'(0) - mag_d) : mag_d);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StEmpty;
      mag_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      op1_q       <= '0;
      entry_val_q <= '0;
      enter_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      op1_q       <= op1_d;
      entry_val_q <= entry_val_d;
      enter_q     <= enter_d;
      err_q       <= err_d;
    end
  end

`ifdef OPERAND_ENTRY_BKSP_EN
  // Partial-magnitude stack: slot n holds the magnitude before digit n+1.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      stack_q[cnt_q] <= mag_q;
    end
  end
`endif

  assign op1_o         = op1_q;
  assign enter_o       = enter_q;
  assign entry_val_o   = entry_val_q;
  assign digit_count_o = cnt_q;
  assign neg_o         = neg_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed vector table, reset sequence and
// randomized keys checked against an integer-level model.
module tb_operand_entry;

  localparam int W = 9;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         key_valid_i = 1'b0;
  logic [3:0]   key_code_i = 4'd0;
  logic [W-1:0] op1_o;
  logic         enter_o;
  logic [W-1:0] entry_val_o;
  logic [1:0]   digit_count_o;
  logic         neg_o;
  logic         err_o;

  int n_tests = 0;
  int n_fail  = 0;

  operand_entry #(.Width(W), .MaxDigits(3)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .key_valid_i   (key_valid_i),
    .key_code_i    (key_code_i),
    .op1_o         (op1_o),
    .enter_o       (enter_o),
    .entry_val_o   (entry_val_o),
    .digit_count_o (digit_count_o),
    .neg_o         (neg_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: plain integers, locked flag, queue of earlier magnitudes.
  int m_mag, m_cnt, m_op1;
  bit m_neg, m_locked, m_enter, m_err;
  int m_hist[$];

  function automatic void model_reset();
    m_mag = 0; m_cnt = 0; m_op1 = 0;
    m_neg = 0; m_locked = 0; m_enter = 0; m_err = 0;
    m_hist.delete();
  endfunction

  function automatic int model_entry();
    return (m_neg ? -m_mag : m_mag) & 32'h1FF;
  endfunction

  function automatic void model_clear();
    m_mag = 0; m_cnt = 0; m_neg = 0; m_locked = 0;
    m_hist.delete();
  endfunction

  function automatic void model_step(bit v, int c);
    m_enter = 0;
    m_err   = 0;
    if (!v) return;
    if (c <= 9) begin
      if (m_locked) m_err = 1;
      else if (m_cnt == 3) begin m_err = 1; m_locked = 1; end
      else if (m_mag * 10 + c > (m_neg ? 256 : 255)) m_err = 1;
      else begin
        m_hist.push_back(m_mag);
        m_mag = m_mag * 10 + c;
        m_cnt++;
      end
    end else if (c == 10) begin
      if (m_locked || (m_neg && m_mag > 255)) m_err = 1;
      else m_neg = !m_neg;
    end else if (c == 11) begin
      model_clear();
    end else if (c == 13) begin
      if (m_cnt == 0) m_err = 1;
      else begin
        m_op1   = model_entry();
        m_enter = 1;
        model_clear();
      end
    end else if (c == 12) begin
`ifdef OPERAND_ENTRY_BKSP_EN
      if (m_cnt == 0) m_err = 1;
      else begin
        m_mag = m_hist.pop_back();
        m_cnt--;
        m_locked = 0;
      end
`endif
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int op1, bit en, int ev, int cnt, bit ng, bit er);
    chk({tag, ".op1"}, int'(op1_o), op1);
    chk({tag, ".enter"}, int'(enter_o), int'(en));
    chk({tag, ".entry_val"}, int'(entry_val_o), ev);
    chk({tag, ".digit_count"}, int'(digit_count_o), cnt);
    chk({tag, ".neg"}, int'(neg_o), int'(ng));
    chk({tag, ".err"}, int'(err_o), int'(er));
  endtask

  // One key per cycle; outputs sampled 1 time unit after the edge.
  task automatic key(bit v, int c);
    key_valid_i = v;
    key_code_i  = 4'(c);
    model_step(v, c);
    @(posedge clk_i);
    #1;
    key_valid_i = 1'b0;
  endtask

  task automatic do_reset(int cycles, bit v, int c);
    rst_i       = 1'b1;
    key_valid_i = v;
    key_code_i  = 4'(c);
    repeat (cycles) @(posedge clk_i);
    #1;
    rst_i       = 1'b0;
    key_valid_i = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit v; int c; int op1; bit en; int ev; int cnt; bit ng; bit er;
  } vec_t;
  vec_t vecs[$];

  task automatic add(bit v, int c, int op1, bit en, int ev, int cnt, bit ng, bit er);
    vec_t t;
    t.v = v; t.c = c; t.op1 = op1; t.en = en; t.ev = ev; t.cnt = cnt; t.ng = ng; t.er = er;
    vecs.push_back(t);
  endtask

  initial begin
    // Directed table, starting from reset with op1 = 0.
    add(1, 1, 0, 0, 1, 1, 0, 0);
    add(1, 2, 0, 0, 12, 2, 0, 0);
    add(1, 3, 0, 0, 123, 3, 0, 0);
    add(1, 13, 123, 1, 0, 0, 0, 0);
    add(0, 13, 123, 0, 0, 0, 0, 0);
    add(1, 2, 123, 0, 2, 1, 0, 0);
    add(1, 5, 123, 0, 25, 2, 0, 0);
    add(1, 6, 123, 0, 25, 2, 0, 1);
    add(1, 10, 123, 0, 487, 2, 1, 0);
    add(1, 6, 123, 0, 256, 3, 1, 0);
    add(1, 10, 123, 0, 256, 3, 1, 1);
    add(1, 13, 256, 1, 0, 0, 0, 0);
    add(1, 13, 256, 0, 0, 0, 0, 1);
    add(1, 9, 256, 0, 9, 1, 0, 0);
    add(1, 9, 256, 0, 99, 2, 0, 0);
    add(1, 9, 256, 0, 99, 2, 0, 1);
    add(1, 9, 256, 0, 99, 2, 0, 1);
    add(1, 13, 99, 1, 0, 0, 0, 0);
    add(1, 7, 99, 0, 7, 1, 0, 0);
    add(1, 7, 99, 0, 77, 2, 0, 0);
    add(1, 11, 99, 0, 0, 0, 0, 0);
    add(1, 13, 99, 0, 0, 0, 0, 1);
    add(1, 10, 99, 0, 0, 0, 1, 0);
    add(1, 13, 99, 0, 0, 0, 1, 1);
    add(1, 11, 99, 0, 0, 0, 0, 0);
    add(1, 0, 99, 0, 0, 1, 0, 0);
    add(1, 0, 99, 0, 0, 2, 0, 0);
    add(1, 7, 99, 0, 7, 3, 0, 0);
    add(1, 1, 99, 0, 7, 3, 0, 1);
    add(1, 10, 99, 0, 7, 3, 0, 1);
    add(1, 2, 99, 0, 7, 3, 0, 1);
    add(1, 13, 7, 1, 0, 0, 0, 0);
    add(1, 14, 7, 0, 0, 0, 0, 0);
    add(1, 15, 7, 0, 0, 0, 0, 0);
    add(1, 1, 7, 0, 1, 1, 0, 0);
    add(1, 2, 7, 0, 12, 2, 0, 0);
`ifdef OPERAND_ENTRY_BKSP_EN
    add(1, 12, 7, 0, 1, 1, 0, 0);
    add(1, 5, 7, 0, 15, 2, 0, 0);
    add(1, 13, 15, 1, 0, 0, 0, 0);
    add(1, 12, 15, 0, 0, 0, 0, 1);
    add(1, 10, 15, 0, 0, 0, 1, 0);
    add(1, 1, 15, 0, 511, 1, 1, 0);
    add(1, 12, 15, 0, 0, 0, 1, 0);
    add(1, 13, 15, 0, 0, 0, 1, 1);
    add(1, 11, 15, 0, 0, 0, 0, 0);
`else
    add(1, 12, 7, 0, 12, 2, 0, 0);
    add(1, 5, 7, 0, 125, 3, 0, 0);
    add(1, 13, 125, 1, 0, 0, 0, 0);
    add(1, 12, 125, 0, 0, 0, 0, 0);
`endif

    do_reset(2, 1'b0, 0);
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    // Reset mid-entry, with a key held valid to show reset wins.
    key(1, 4);
    key(1, 2);
    chk("pre_reset.entry_val", int'(entry_val_o), 42);
    do_reset(2, 1'b1, 5);
    chk_all("mid_reset", 0, 0, 0, 0, 0, 0);
    key(1, 13);
    chk_all("enter_after_reset", 0, 0, 0, 0, 0, 1);

    do_reset(1, 1'b0, 0);
    foreach (vecs[i]) begin
      key(vecs[i].v, vecs[i].c);
      chk_all($sformatf("vec%0d", i), vecs[i].op1, vecs[i].en, vecs[i].ev,
              vecs[i].cnt, vecs[i].ng, vecs[i].er);
    end

    // Randomized keys against the model, with occasional resets.
    do_reset(1, 1'b0, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1, 1'b1, int'($urandom_range(0, 15)));
      end else begin
        key(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));
      end
      chk_all($sformatf("rnd%0d", i), m_op1, m_enter, model_entry(), m_cnt, m_neg, m_err);
      if (enter_o && err_o) chk("rnd.enter_err_exclusive", 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
